seg_bcd_converter: RTL

//   Sequential binary-to-BCD converter that runs the double-dabble algorithm, one bit per clock.

---
 rtl/seg_bcd_converter.sv | 99 +++++++++
 1 files changed

// File: rtl/seg_bcd_converter.sv
// seg_bcd_converter: sequential double-dabble binary-to-BCD converter, one input bit per clock
module seg_bcd_converter #(
  parameter int IN_W    = 32,
  parameter int DIGITS  = 8,
  parameter int INT_DIG = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic                  ovf
);
  localparam int AW = 4 * INT_DIG;
  localparam int CW = $clog2(IN_W + 1);
  typedef enum logic {IDLE, CONV} state_t;
  state_t              state_q, state_d;
  logic [IN_W-1:0]     mag_q, mag_d;
  logic [AW-1:0]       acc_q, acc_d, adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                neg_pend_q, neg_pend_d;
  logic                done_q, done_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;
  logic                last, take, in_neg;
  assign last   = cnt_q == CW'(IN_W - 1);
  assign take   = state_q == IDLE && start;
  assign in_neg = signed_mode & bin_in[IN_W-1];
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < INT_DIG; i++)
      adj[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_pend_q <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_pend_q <= neg_pend_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (start ? CONV : IDLE) : (last ? IDLE : CONV);
  end
  always_comb begin
    mag_d      = mag_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_pend_d = neg_pend_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    done_d     = state_q == CONV && last;
    if (take) begin
      mag_d      = in_neg ? -bin_in : bin_in;
      neg_pend_d = in_neg;
      acc_d      = '0;
      cnt_d      = '0;
    end
    if (state_q == CONV) begin
      acc_d = {adj[AW-2:0], mag_q[IN_W-1]};
      mag_d = mag_q << 1;
      cnt_d = cnt_q + CW'(1);
    end
    // results land on the same edge as the final shift
    if (done_d) begin
      bcd_d = acc_d[4*DIGITS-1:0];
      ovf_d = |acc_d[AW-1:4*DIGITS];
      neg_d = neg_pend_q;
    end
  end
  always_comb begin
    busy    = state_q == CONV;
    done    = done_q;
    bcd_out = bcd_q;
    neg     = neg_q;
    ovf     = ovf_q;
  end
endmodule
